// File: rtl/pipa_sim_pkg.sv
// Shared types and helpers for the PIPA stimulus generator.
// Slot polarity, bias encoding and the plus/minus slot decode live here.
package pipa_sim_pkg;

    localparam logic POL_PLUS  = 1'b1;
    localparam logic POL_MINUS = 1'b0;

    typedef enum logic [1:0] {
        BIAS_NONE = 2'b00,
        BIAS_POS  = 2'b01,
        BIAS_NEG  = 2'b11
    } bias_t;

    // Returns POL_PLUS when the slot emits plus pulses. A positive bias
    // steals the first minus slot, a negative bias gives up the last plus slot.
    function automatic logic plus_slot(input int slot, input bias_t bias, input int h);
        logic pol;
        pol = (slot < h) ? POL_PLUS : POL_MINUS;
        if ((bias == BIAS_POS) && (slot == h)) begin
            pol = POL_PLUS;
        end
        if ((bias == BIAS_NEG) && (slot == h - 1)) begin
            pol = POL_MINUS;
        end
        return pol;
    endfunction

endpackage

// File: rtl/pipa_axis.sv
// One simulated accelerometer axis: rate accumulator, moding bias,
// slot polarity decode, pulse gating and signed net pulse counter.
module pipa_axis
    import pipa_sim_pkg::*;
#(
    parameter int CYCLE_LEN = 6,
    parameter int ACC_W     = 16,
    parameter int CNT_W     = 16,
    parameter int SLOT_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ACC_W-1:0]  rate,
    input  logic              boundary,
    input  logic              cnt_evt,
    input  logic              clr,
    input  logic [SLOT_W-1:0] slot,
    input  logic              pipdat,
    output logic              pipa_p,
    output logic              pipa_m,
    output logic [CNT_W-1:0]  net_cnt
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mag;
    logic [ACC_W:0]   acc_sum;
    bias_t            bias;
    bias_t            bias_next;
    logic             pol;

    // Two's-complement negate; the most-negative rate maps to 2^(ACC_W-1).
    always_comb begin
        mag       = rate[ACC_W-1] ? (~rate + 1'b1) : rate;
        acc_sum   = {1'b0, acc} + {1'b0, mag};
        bias_next = BIAS_NONE;
        if (acc_sum[ACC_W]) begin
            bias_next = rate[ACC_W-1] ? BIAS_NEG : BIAS_POS;
        end
    end

    always_comb begin
        pol    = plus_slot(int'(slot), bias, CYCLE_LEN / 2);
        pipa_p = enable & pipdat & (pol == POL_PLUS);
        pipa_m = enable & pipdat & (pol == POL_MINUS);
    end

    // A disabled axis freezes acc but drops its bias immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            bias <= BIAS_NONE;
        end else if (!enable) begin
            bias <= BIAS_NONE;
        end else if (boundary) begin
            acc  <= acc_sum[ACC_W-1:0];
            bias <= bias_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            net_cnt <= '0;
        end else if (clr) begin
            net_cnt <= '0;
        end else if (cnt_evt && enable) begin
            if (pol == POL_PLUS) begin
                net_cnt <= net_cnt + CNT_W'(1);
            end else begin
                net_cnt <= net_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipa_sim.sv
// PIPA stimulus generator top: PIPASW/PIPDAT edge detection, the shared
// moding slot counter and AXES independent axis instances.
module pipa_sim
    import pipa_sim_pkg::*;
#(
    parameter int AXES      = 3,
    parameter int CYCLE_LEN = 6,
    parameter int ACC_W     = 16,
    parameter int CNT_W     = 16,
    localparam int SLOT_W   = $clog2(CYCLE_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipasw,
    input  logic                  pipdat,
    input  logic [AXES-1:0]       enable,
    input  logic [AXES*ACC_W-1:0] rate,
    input  logic                  clr,
    output logic [AXES-1:0]       pipa_p,
    output logic [AXES-1:0]       pipa_m,
    output logic [AXES*CNT_W-1:0] net_cnt,
    output logic [SLOT_W-1:0]     slot
);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CYCLE_LEN - 1);

    logic pipasw_q;
    logic pipdat_q;
    logic sw_rise;
    logic dat_rise;
    logic boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipasw_q <= 1'b0;
            pipdat_q <= 1'b0;
        end else begin
            pipasw_q <= pipasw;
            pipdat_q <= pipdat;
        end
    end

    // The wrap edge is the cycle boundary; axes latch their new bias on it
    // so the bias covers every slot of the following cycle.
    always_comb begin
        sw_rise  = pipasw & ~pipasw_q;
        dat_rise = pipdat & ~pipdat_q;
        boundary = sw_rise && (slot == SLOT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (sw_rise) begin
            slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        end
    end

    for (genvar i = 0; i < AXES; i++) begin : g_axis
        pipa_axis #(
            .CYCLE_LEN (CYCLE_LEN),
            .ACC_W     (ACC_W),
            .CNT_W     (CNT_W),
            .SLOT_W    (SLOT_W)
        ) u_axis (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable   (enable[i]),
            .rate     (rate[i*ACC_W +: ACC_W]),
            .boundary (boundary),
            .cnt_evt  (dat_rise),
            .clr      (clr),
            .slot     (slot),
            .pipdat   (pipdat),
            .pipa_p   (pipa_p[i]),
            .pipa_m   (pipa_m[i]),
            .net_cnt  (net_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_pipa_sim.sv
// Directed bench for pipa_sim: moding split, rate bias, enable hold,
// clear priority and mid-cycle reset with hand-computed expectations.
module tb_pipa_sim;

    localparam int AXES      = 3;
    localparam int CYCLE_LEN = 6;
    localparam int ACC_W     = 8;
    localparam int CNT_W     = 16;

    logic                  clk;
    logic                  rst_n;
    logic                  pipasw;
    logic                  pipdat;
    logic [AXES-1:0]       enable;
    logic [AXES*ACC_W-1:0] rate;
    logic                  clr;
    logic [AXES-1:0]       pipa_p;
    logic [AXES-1:0]       pipa_m;
    logic [AXES*CNT_W-1:0] net_cnt;
    logic [2:0]            slot;

    int checks   = 0;
    int failures = 0;

    pipa_sim #(
        .AXES      (AXES),
        .CYCLE_LEN (CYCLE_LEN),
        .ACC_W     (ACC_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pipasw  (pipasw),
        .pipdat  (pipdat),
        .enable  (enable),
        .rate    (rate),
        .clr     (clr),
        .pipa_p  (pipa_p),
        .pipa_m  (pipa_m),
        .net_cnt (net_cnt),
        .slot    (slot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [CNT_W-1:0] net_of(input int i);
        return net_cnt[i*CNT_W +: CNT_W];
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        pipasw = 1'b0;
        pipdat = 1'b0;
        clr    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_dat(output logic [AXES-1:0] p, output logic [AXES-1:0] m);
        pipdat = 1'b1;
        @(negedge clk);
        p = pipa_p;
        m = pipa_m;
        pipdat = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_sw();
        pipasw = 1'b1;
        @(negedge clk);
        pipasw = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_pair(output logic [AXES-1:0] p, output logic [AXES-1:0] m);
        pulse_dat(p, m);
        pulse_sw();
    endtask

    task automatic test_reset();
        enable = '1;
        rate   = '0;
        apply_reset();
        checks++; if (slot !== 3'd0) begin failures++; $display("FAIL reset_slot got=%0d exp=0", slot); end
        checks++; if (pipa_p !== 3'b000) begin failures++; $display("FAIL reset_pipa_p got=%b exp=000", pipa_p); end
        checks++; if (pipa_m !== 3'b000) begin failures++; $display("FAIL reset_pipa_m got=%b exp=000", pipa_m); end
        checks++; if (net_cnt !== '0) begin failures++; $display("FAIL reset_net got=%h exp=0", net_cnt); end
    endtask

    task automatic test_rest();
        logic [AXES-1:0] p, m;
        logic [AXES-1:0] exp_p;
        enable = '1;
        rate   = '0;
        apply_reset();
        for (int k = 0; k < CYCLE_LEN; k++) begin
            do_pair(p, m);
            exp_p = (k < 3) ? 3'b111 : 3'b000;
            checks++; if (p !== exp_p) begin failures++; $display("FAIL rest_p slot%0d got=%b exp=%b", k, p, exp_p); end
            checks++; if (m !== ~exp_p) begin failures++; $display("FAIL rest_m slot%0d got=%b exp=%b", k, m, ~exp_p); end
        end
        checks++; if (net_cnt !== '0) begin failures++; $display("FAIL rest_net got=%h exp=0", net_cnt); end
        checks++; if (slot !== 3'd0) begin failures++; $display("FAIL rest_wrap_slot got=%0d exp=0", slot); end
    endtask

    task automatic test_rate_pos();
        logic [AXES-1:0] p, m;
        int p_early, p_c5, m_c5;
        p_early = 0; p_c5 = 0; m_c5 = 0;
        enable = '1;
        rate   = {8'd0, 8'd0, 8'd64};
        apply_reset();
        for (int k = 0; k < 30; k++) begin
            do_pair(p, m);
            if (k >= 24) begin
                p_c5 += int'(p[0]);
                m_c5 += int'(m[0]);
            end else begin
                p_early += int'(p[0]);
            end
        end
        checks++; if (p_early != 12) begin failures++; $display("FAIL pos_early_plus got=%0d exp=12", p_early); end
        checks++; if (p_c5 != 4) begin failures++; $display("FAIL pos_c5_plus got=%0d exp=4", p_c5); end
        checks++; if (m_c5 != 2) begin failures++; $display("FAIL pos_c5_minus got=%0d exp=2", m_c5); end
        checks++; if (net_of(0) !== 16'd2) begin failures++; $display("FAIL pos_net0 got=%h exp=0002", net_of(0)); end
        checks++; if (net_of(1) !== 16'd0) begin failures++; $display("FAIL pos_net1 got=%h exp=0000", net_of(1)); end
        checks++; if (net_of(2) !== 16'd0) begin failures++; $display("FAIL pos_net2 got=%h exp=0000", net_of(2)); end
    endtask

    task automatic test_rate_neg();
        logic [AXES-1:0] p, m;
        int p_c3, m_c3;
        p_c3 = 0; m_c3 = 0;
        enable = '1;
        rate   = {8'd0, 8'h80, 8'd0};
        apply_reset();
        for (int k = 0; k < 18; k++) begin
            do_pair(p, m);
            if (k >= 12) begin
                p_c3 += int'(p[1]);
                m_c3 += int'(m[1]);
            end
        end
        checks++; if (p_c3 != 2) begin failures++; $display("FAIL neg_c3_plus got=%0d exp=2", p_c3); end
        checks++; if (m_c3 != 4) begin failures++; $display("FAIL neg_c3_minus got=%0d exp=4", m_c3); end
        checks++; if (net_of(1) !== 16'hFFFE) begin failures++; $display("FAIL neg_net1 got=%h exp=fffe", net_of(1)); end
        checks++; if (net_of(0) !== 16'd0) begin failures++; $display("FAIL neg_net0 got=%h exp=0000", net_of(0)); end
    endtask

    task automatic test_disable();
        logic [AXES-1:0] p, m;
        logic seen;
        seen   = 1'b0;
        enable = 3'b011;
        rate   = {8'd100, 8'd0, 8'd0};
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            do_pair(p, m);
            seen = seen | p[2] | m[2];
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL dis_pulses got=%b exp=0", seen); end
        checks++; if (net_of(2) !== 16'd0) begin failures++; $display("FAIL dis_net2 got=%h exp=0000", net_of(2)); end
        // Held acc=0: carry comes on the 3rd enabled boundary, not the 1st.
        enable = 3'b111;
        for (int k = 0; k < 18; k++) do_pair(p, m);
        checks++; if (net_of(2) !== 16'd0) begin failures++; $display("FAIL reen_net2_early got=%h exp=0000", net_of(2)); end
        for (int k = 0; k < 6; k++) do_pair(p, m);
        checks++; if (net_of(2) !== 16'd2) begin failures++; $display("FAIL reen_net2 got=%h exp=0002", net_of(2)); end
    endtask

    task automatic test_clr();
        logic [AXES-1:0] p, m;
        do_pair(p, m);
        checks++; if (net_of(0) !== 16'd1) begin failures++; $display("FAIL clr_pre_net0 got=%h exp=0001", net_of(0)); end
        pipdat = 1'b1;
        clr    = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (net_cnt !== '0) begin failures++; $display("FAIL clr_net got=%h exp=0", net_cnt); end
        pipdat = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (net_cnt !== '0) begin failures++; $display("FAIL clr_discard got=%h exp=0", net_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [AXES-1:0] p, m;
        enable = '1;
        rate   = {8'd0, 8'd0, 8'd64};
        apply_reset();
        for (int k = 0; k < 27; k++) do_pair(p, m);
        do_pair(p, m);
        checks++; if (p[0] !== 1'b1) begin failures++; $display("FAIL mid_bias_slot3 got=%b exp=1", p[0]); end
        checks++; if (slot !== 3'd4) begin failures++; $display("FAIL mid_pre_slot got=%0d exp=4", slot); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (slot !== 3'd0) begin failures++; $display("FAIL mid_rst_slot got=%0d exp=0", slot); end
        checks++; if ((pipa_p | pipa_m) !== 3'b000) begin failures++; $display("FAIL mid_rst_out got=%b exp=000", pipa_p | pipa_m); end
        checks++; if (net_cnt !== '0) begin failures++; $display("FAIL mid_rst_net got=%h exp=0", net_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_sw();
        checks++; if (slot !== 3'd1) begin failures++; $display("FAIL mid_first_slot got=%0d exp=1", slot); end
        pulse_dat(p, m);
        checks++; if (p !== 3'b111) begin failures++; $display("FAIL mid_first_plus got=%b exp=111", p); end
        pulse_sw();
        pulse_sw();
        pulse_dat(p, m);
        checks++; if (m !== 3'b111) begin failures++; $display("FAIL mid_bias_cleared got=%b exp=111", m); end
    endtask

    initial begin
        rst_n  = 1'b0;
        pipasw = 1'b0;
        pipdat = 1'b0;
        clr    = 1'b0;
        enable = '0;
        rate   = '0;
        test_reset();
        test_rest();
        test_rate_pos();
        test_rate_neg();
        test_disable();
        test_clr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipa_sim.md
Name: pipa_sim

Overview:
- Parametrised PIPA (pulsed integrating pendulous accelerometer) stimulus generator for the FPGA AGC top level.
- Replaces the fixed 3-axis, 3-3 moding counter with N independent axes.
- Each axis has a programmable moding cycle length and a signed acceleration rate. The rate biases the plus/minus pulse split: 3-3 at rest, 4-2 or 2-4 under acceleration.
- Also keeps a per-axis net pulse count that the monitor reads.

Parameters:
- AXES, 3, number of simulated accelerometer axes.
- CYCLE_LEN, 6, PIPASW interrogations per moding cycle; must be even and >= 4.
- ACC_W, 16, width of the per-axis rate and phase accumulator.
- CNT_W, 16, width of the per-axis signed net pulse counter.

Ports:
- clk, in, 1, prop_clk domain clock; the AGC-side PIPASW and PIPDAT are synchronous to it.
- rst_n, in, 1, asynchronous active-low reset.
- pipasw, in, 1, AGC PIPA interrogate strobe; its rising edge advances the moding slot.
- pipdat, in, 1, AGC PIPA data strobe.
- enable, in, AXES, per-axis enable.
- rate, in, AXES*ACC_W, per-axis signed two's-complement rate, axis i at bits [i*ACC_W +: ACC_W].
- clr, in, 1, synchronous clear of all net counters.
- pipa_p, out, AXES, plus-pulse line per axis.
- pipa_m, out, AXES, minus-pulse line per axis.
- net_cnt, out, AXES*CNT_W, per-axis signed net count (plus minus minus).
- slot, out, clog2(CYCLE_LEN), current moding slot.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low. All state is reset by it.
- Reset values: slot=0, all bias=0, all accumulators=0, net_cnt=0, edge-detect registers=0. pipa_p and pipa_m are therefore 0.
- Edge detection:
  - pipasw and pipdat are each registered once.
  - A rising edge is current=1 and previous=0.
  - slot updates on the clk edge after the cycle in which the pipasw edge is detected (latency 1).
- Slot counter:
  - On each pipasw edge, slot = slot+1.
  - At CYCLE_LEN-1 it wraps to 0. That wrap is the cycle-boundary event.
- Slot polarity per axis (H = CYCLE_LEN/2):
  - bias=0: slots 0..H-1 are plus, H..CYCLE_LEN-1 are minus.
  - bias=+1: slot H also becomes plus.
  - bias=-1: slot H-1 also becomes minus.
- Outputs:
  - pipa_p[i] = enable[i] & pipdat & plus(slot); pipa_m[i] = enable[i] & pipdat & minus(slot).
  - These are combinational from the registered slot and bias and the live pipdat. This matches legacy timing: a pulse lasts as long as pipdat.
- Rate accumulator, evaluated on the boundary event for each enabled axis:
  - mag = |rate| as an ACC_W-bit unsigned value (most-negative rate gives mag 2^(ACC_W-1)).
  - {carry, acc} = acc + mag.
  - bias = carry ? sign(rate) : 0.
  - The new bias holds for the entire following cycle.
  - Maximum representable net rate is 2 counts per cycle.
- Rate changes mid-cycle have no effect until the next boundary.
- A disabled axis holds its acc, forces bias=0, emits no pulses and does not count. Re-enabling resumes from the held acc.
- Net count:
  - On each pipdat rising edge, each enabled axis adds +1 if its current slot is plus and -1 if minus.
  - Arithmetic is CNT_W-bit two's-complement, wrapping.
- Simultaneous events:
  - clr together with a count event: clr wins, net_cnt=0.
  - pipasw edge together with a pipdat edge: the count uses the slot value before the advance.
- Reset asserted mid-cycle: everything returns to reset values immediately; the first pipasw edge after release gives slot=1.

Decomposition:
- Package pipa_sim_pkg holds:
  - slot-polarity constants (POL_PLUS, POL_MINUS);
  - bias encoding (BIAS_NONE, BIAS_POS, BIAS_NEG as a 2-bit type);
  - a function plus_slot(slot, bias, H).
- Sub-module pipa_axis, instantiated AXES times by generate, holds one axis's accumulator, bias, polarity decode and net counter.
- The top level owns edge detection and the shared slot counter.

Test Plan:
- rate=0, enable=all, 6 pipasw/pipdat pairs, CYCLE_LEN=6 -> each axis gives 3 pipa_p then 3 pipa_m pulses; net_cnt=0.
- ACC_W=8, rate[0]=64, 30 pairs (5 cycles) -> axis 0 carries at the 4th boundary; cycle 5 gives 4 plus / 2 minus; net_cnt[0]=+2. Other axes at rate 0 stay at 0.
- ACC_W=8, rate[1]=-128, 18 pairs -> carry at the 2nd boundary; cycle 3 gives 2 plus / 4 minus; net_cnt[1]=-2.
- enable[2]=0 for 12 pairs with rate[2]=100 -> pipa_p[2]=pipa_m[2]=0 throughout, net_cnt[2] unchanged, acc held. On re-enable, accumulation resumes from the held value.
- clr asserted in the same cycle as a pipdat edge -> net_cnt=0 next cycle, and the event is discarded.
- rst_n pulled low at slot=4 with bias=+1 -> slot=0, bias=0 and outputs 0 immediately. The next pipasw edge gives slot=1 and polarity plus.
